id_exe: RTL and testbench
=========================

Name: id_exe

Overview:
- Pipeline register between the decode stage and the execute stage of the 5-stage RV32 core.
- Captures decode results every cycle: instruction, PC, operands, write-back control and exception flags.
- Applies stall, bubble and flush control.
- Feeds the load-use hazard signals (previous-instruction-is-load, destination register) back to decode.

Parameters:
- ADDR_WIDTH, 32, instruction address width
- DATA_WIDTH, 32, instruction width
- RADDR_WIDTH, 5, register file address width
- RDATA_WIDTH, 32, register data width
- NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- stall_id_i  in  1  decode stage held this cycle
- stall_exe_i  in  1  execute stage held this cycle
- flush_i  in  1  squash contents (taken branch/jump, trap, mret)
- inst_i  in  DATA_WIDTH  decoded instruction
- inst_addr_i  in  ADDR_WIDTH  its PC
- op1_i  in  RDATA_WIDTH  forwarded operand 1
- op2_i  in  RDATA_WIDTH  forwarded operand 2
- reg_we_i  in  1  write-back enable
- reg_waddr_i  in  RADDR_WIDTH  write-back register
- exception_i  in  32  exception flags (bit0 mret, bit1 ecall)
- inst_o  out  DATA_WIDTH  registered instruction
- inst_addr_o  out  ADDR_WIDTH  registered PC
- op1_o  out  RDATA_WIDTH  registered operand 1
- op2_o  out  RDATA_WIDTH  registered operand 2
- reg_we_o  out  1  registered write enable
- reg_waddr_o  out  RADDR_WIDTH  registered write address
- exception_o  out  32  registered exception flags
- pre_inst_is_load_o  out  1  registered instruction is a load (opcode 7'b0000011)
- exe_rd_o  out  RADDR_WIDTH  rd field of registered instruction (inst_o[11:7])
- bubble_cnt_o  out  32  count of bubbles inserted

Behaviour:
- Reset (rst_i=1, asynchronous, any time including mid-stall):
  - inst_o=NOP_INST.
  - inst_addr_o, op1_o, op2_o, exception_o, bubble_cnt_o = 0.
  - reg_we_o=0, reg_waddr_o=0.
  - Reset dominates all other inputs.
- Per rising edge, priority order, first match wins:
  1. flush_i=1: load bubble (NOP_INST, zeros, reg_we_o=0, exception_o=0); bubble_cnt_o unchanged. Flush overrides stall.
  2. stall_id_i=1 and stall_exe_i=0: load bubble; bubble_cnt_o += 1 (load-use stall bubble).
  3. stall_exe_i=1: hold all registers; counter unchanged.
  4. Otherwise: capture all inputs.
- Bubble values: inst_o=NOP_INST; inst_addr_o, op1_o, op2_o, reg_waddr_o = 0.
- Latency: exactly one cycle from input to output when not stalled.
- Flush clears exception_o, so a squashed ecall/mret never reaches the CSR stage.
- Derived outputs:
  - pre_inst_is_load_o is combinational from registered inst_o[6:0]==7'b0000011; it is 0 for a bubble.
  - exe_rd_o is combinational from inst_o[11:7].
  - pre_inst_is_load_o and exe_rd_o change only on a clock edge or reset.
- bubble_cnt_o wraps from 32'hFFFFFFFF to 0 with no saturation.
- Load-use stall sequence:
  - Decode asserts the stall while the load sits here.
  - Next edge: the load advances and a bubble enters here.
  - pre_inst_is_load_o drops to 0, releasing the stall after exactly one bubble.
- No X propagation: every register has a defined reset value.

Test Plan:
1. Reset then capture: deassert rst_i; drive inst_i=32'h00500093, inst_addr_i=32'h80000000, op1_i=0, op2_i=5, reg_we_i=1, reg_waddr_i=1. Next edge: outputs equal inputs, pre_inst_is_load_o=0, exe_rd_o=1.
2. Load-use: capture lw x5,0(x1) (32'h0000A283). Expect pre_inst_is_load_o=1, exe_rd_o=5. Assert stall_id_i=1, stall_exe_i=0 for one edge. Expect inst_o=32'h00000013, reg_we_o=0, pre_inst_is_load_o=0, bubble_cnt_o=1.
3. Hold: with a valid add in the register, assert stall_exe_i=1 (stall_id_i=1) for 3 edges while inputs change. Outputs stay constant and bubble_cnt_o is unchanged.
4. Flush priority: flush_i=1, stall_id_i=1, stall_exe_i=1, inputs carrying ecall (exception_i=2). Next edge: bubble, exception_o=0, bubble_cnt_o unchanged.
5. Async reset mid-operation: pulse rst_i between clock edges while a load is registered. Outputs reach reset values immediately without a clock edge, and pre_inst_is_load_o=0.
6. Counter wrap: force bubble_cnt_o to 32'hFFFFFFFF, insert one stall bubble. Expect bubble_cnt_o=0.

Source files
------------

// File: rtl/id_exe.sv
// Decode-to-execute pipeline register with stall, bubble and flush control.
// Also returns the load-use hazard signals (registered load flag, rd) to decode.
module id_exe #(
  parameter int              ADDR_WIDTH  = 32,
  parameter int              DATA_WIDTH  = 32,
  parameter int              RADDR_WIDTH = 5,
  parameter int              RDATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INST = 32'h00000013
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_id_i,
  input  logic                   stall_exe_i,
  input  logic                   flush_i,
  input  logic [DATA_WIDTH-1:0]  inst_i,
  input  logic [ADDR_WIDTH-1:0]  inst_addr_i,
  input  logic [RDATA_WIDTH-1:0] op1_i,
  input  logic [RDATA_WIDTH-1:0] op2_i,
  input  logic                   reg_we_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic [31:0]            exception_i,
  output logic [DATA_WIDTH-1:0]  inst_o,
  output logic [ADDR_WIDTH-1:0]  inst_addr_o,
  output logic [RDATA_WIDTH-1:0] op1_o,
  output logic [RDATA_WIDTH-1:0] op2_o,
  output logic                   reg_we_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic [31:0]            exception_o,
  output logic                   pre_inst_is_load_o,
  output logic [RADDR_WIDTH-1:0] exe_rd_o,
  output logic [31:0]            bubble_cnt_o
);

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  logic [DATA_WIDTH-1:0]  inst_q,      inst_d;
  logic [ADDR_WIDTH-1:0]  inst_addr_q, inst_addr_d;
  logic [RDATA_WIDTH-1:0] op1_q,       op1_d;
  logic [RDATA_WIDTH-1:0] op2_q,       op2_d;
  logic                   reg_we_q,    reg_we_d;
  logic [RADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
  logic [31:0]            exception_q, exception_d;
  logic [31:0]            bubble_cnt_q, bubble_cnt_d;
  logic                   load_bubble;

  // Flush beats everything; a decode-only stall turns into a counted bubble.
  always_comb begin
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    reg_we_d     = reg_we_q;
    reg_waddr_d  = reg_waddr_q;
    exception_d  = exception_q;
    bubble_cnt_d = bubble_cnt_q;
    load_bubble  = 1'b0;

    if (flush_i) begin
      load_bubble = 1'b1;
    end else if (stall_id_i && !stall_exe_i) begin
      load_bubble  = 1'b1;
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else if (!stall_exe_i) begin
      inst_d      = inst_i;
      inst_addr_d = inst_addr_i;
      op1_d       = op1_i;
      op2_d       = op2_i;
      reg_we_d    = reg_we_i;
      reg_waddr_d = reg_waddr_i;
      exception_d = exception_i;
    end

    if (load_bubble) begin
      inst_d      = NOP_INST;
      inst_addr_d = '0;
      op1_d       = '0;
      op2_d       = '0;
      reg_we_d    = 1'b0;
      reg_waddr_d = '0;
      exception_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inst_q       <= NOP_INST;
      inst_addr_q  <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      reg_we_q     <= 1'b0;
      reg_waddr_q  <= '0;
      exception_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      reg_we_q     <= reg_we_d;
      reg_waddr_q  <= reg_waddr_d;
      exception_q  <= exception_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign inst_o             = inst_q;
  assign inst_addr_o        = inst_addr_q;
  assign op1_o              = op1_q;
  assign op2_o              = op2_q;
  assign reg_we_o           = reg_we_q;
  assign reg_waddr_o        = reg_waddr_q;
  assign exception_o        = exception_q;
  assign bubble_cnt_o       = bubble_cnt_q;
  // Derived from the register only, so they move solely on an edge or reset.
  assign pre_inst_is_load_o = (inst_q[6:0] == OPC_LOAD);
  assign exe_rd_o           = inst_q[11:7];

endmodule

// File: tb/tb_id_exe.sv
// Directed table-driven bench for the id_exe pipeline register,
// plus hand sequences for async reset mid-cycle and counter wrap.
module tb_id_exe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_id_i, stall_exe_i, flush_i;
  logic [31:0] inst_i, inst_addr_i, op1_i, op2_i;
  logic        reg_we_i;
  logic [4:0]  reg_waddr_i;
  logic [31:0] exception_i;
  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] exception_o;
  logic        pre_inst_is_load_o;
  logic [4:0]  exe_rd_o;
  logic [31:0] bubble_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  id_exe dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .stall_id_i(stall_id_i), .stall_exe_i(stall_exe_i), .flush_i(flush_i),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
    .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .exception_i(exception_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .exception_o(exception_o),
    .pre_inst_is_load_o(pre_inst_is_load_o), .exe_rd_o(exe_rd_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        sid, sex, fl;
    logic [31:0] inst, addr, op1, op2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] exc;
  } in_t;

  typedef struct packed {
    logic [31:0] inst, addr, op1, op2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] exc;
    logic        ld;
    logic [4:0]  rd;
    logic [31:0] cnt;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  function automatic exp_t cap(in_t v, logic ld, logic [4:0] rd, logic [31:0] cnt);
    return '{v.inst, v.addr, v.op1, v.op2, v.we, v.wa, v.exc, ld, rd, cnt};
  endfunction

  function automatic exp_t bub(logic [31:0] cnt);
    return '{32'h00000013, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, cnt};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".inst"},  inst_o,       e.inst);
    check({tag, ".addr"},  inst_addr_o,  e.addr);
    check({tag, ".op1"},   op1_o,        e.op1);
    check({tag, ".op2"},   op2_o,        e.op2);
    check({tag, ".we"},    {31'd0, reg_we_o},           {31'd0, e.we});
    check({tag, ".wa"},    {27'd0, reg_waddr_o},        {27'd0, e.wa});
    check({tag, ".exc"},   exception_o,  e.exc);
    check({tag, ".ld"},    {31'd0, pre_inst_is_load_o}, {31'd0, e.ld});
    check({tag, ".rd"},    {27'd0, exe_rd_o},           {27'd0, e.rd});
    check({tag, ".cnt"},   bubble_cnt_o, e.cnt);
  endtask

  task automatic drive(input in_t v);
    stall_id_i  = v.sid;
    stall_exe_i = v.sex;
    flush_i     = v.fl;
    inst_i      = v.inst;
    inst_addr_i = v.addr;
    op1_i       = v.op1;
    op2_i       = v.op2;
    reg_we_i    = v.we;
    reg_waddr_i = v.wa;
    exception_i = v.exc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    in_t addi_v, lw_v, add_v, ecall_v, mret_v, lw10_v, chg_v, idle_v;

    addi_v  = '{1'b0, 1'b0, 1'b0, 32'h00500093, 32'h80000000, 32'd0,   32'd5, 1'b1, 5'd1,  32'd0};
    lw_v    = '{1'b0, 1'b0, 1'b0, 32'h0000A283, 32'h80000004, 32'h100, 32'd0, 1'b1, 5'd5,  32'd0};
    add_v   = '{1'b0, 1'b0, 1'b0, 32'h002081B3, 32'h80000008, 32'd7,   32'd9, 1'b1, 5'd3,  32'd0};
    ecall_v = '{1'b0, 1'b0, 1'b0, 32'h00000073, 32'h8000000C, 32'd0,   32'd0, 1'b0, 5'd0,  32'd2};
    mret_v  = '{1'b0, 1'b0, 1'b0, 32'h30200073, 32'h80000010, 32'd0,   32'd0, 1'b0, 5'd0,  32'd1};
    lw10_v  = '{1'b0, 1'b0, 1'b0, 32'h0000A503, 32'h80000014, 32'h200, 32'd0, 1'b1, 5'd10, 32'd0};
    chg_v   = '{1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h12345678, 32'hAA,  32'hBB, 1'b1, 5'd31, 32'd2};

    tbl[0]  = '{addi_v, cap(addi_v, 1'b0, 5'd1, 32'd0)};
    tbl[1]  = '{lw_v,   cap(lw_v,   1'b1, 5'd5, 32'd0)};
    idle_v = add_v; idle_v.sid = 1'b1;
    tbl[2]  = '{idle_v, bub(32'd1)};
    tbl[3]  = '{add_v,  cap(add_v,  1'b0, 5'd3, 32'd1)};
    tbl[4]  = '{chg_v,  tbl[3].e};
    chg_v.inst = 32'h0000A283; chg_v.op1 = 32'h55;
    tbl[5]  = '{chg_v,  tbl[3].e};
    chg_v.addr = 32'hFFFFFFFC; chg_v.we = 1'b0;
    tbl[6]  = '{chg_v,  tbl[3].e};
    idle_v = ecall_v; idle_v.sid = 1'b1; idle_v.sex = 1'b1; idle_v.fl = 1'b1;
    tbl[7]  = '{idle_v, bub(32'd1)};
    tbl[8]  = '{ecall_v, cap(ecall_v, 1'b0, 5'd0, 32'd1)};
    tbl[9]  = '{mret_v,  cap(mret_v,  1'b0, 5'd0, 32'd1)};
    idle_v = lw_v; idle_v.fl = 1'b1;
    tbl[10] = '{idle_v, bub(32'd1)};
    idle_v = add_v; idle_v.sid = 1'b1;
    tbl[11] = '{idle_v, bub(32'd2)};
    idle_v = lw_v; idle_v.sex = 1'b1;
    tbl[12] = '{idle_v, bub(32'd2)};
    tbl[13] = '{lw10_v, cap(lw10_v, 1'b1, 5'd10, 32'd2)};

    // Reset held across edges while inputs request a capture.
    rst_i = 1'b1;
    drive(addi_v);
    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset", bub(32'd0));
    rst_i = 1'b0;

    for (int k = 0; k < NV; k++) begin
      drive(tbl[k].i);
      @(posedge clk_i);
      #1;
      check_all($sformatf("v%0d", k), tbl[k].e);
    end

    // Async reset between edges with a load registered.
    #2;
    rst_i = 1'b1;
    #1;
    check_all("async_rst", bub(32'd0));
    #1;
    rst_i = 1'b0;

    // Counter wrap: preload the count, then one stall bubble.
    drive(addi_v);
    @(posedge clk_i);
    #1;
    force dut.bubble_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.bubble_cnt_q;
    #1;
    check("wrap.pre", bubble_cnt_o, 32'hFFFFFFFF);
    idle_v = addi_v; idle_v.sid = 1'b1;
    drive(idle_v);
    @(posedge clk_i);
    #1;
    check_all("wrap", bub(32'd0));
    @(posedge clk_i);
    #1;
    check("wrap.next", bubble_cnt_o, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
